// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 external bus sequencers.
// Phase states, z80fi cycle types and nominal T-state counts.
package z80_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T1H,
        ST_T1L,
        ST_T2H,
        ST_T2L,
        ST_TWH,
        ST_TWL,
        ST_T3H,
        ST_T3L
    } tstate_t;

    typedef enum logic [2:0] {
        CYCLE_NONE   = 3'd0,
        CYCLE_FETCH  = 3'd1,
        CYCLE_RD_MEM = 3'd2,
        CYCLE_WR_MEM = 3'd3,
        CYCLE_RD_IO  = 3'd4,
        CYCLE_WR_IO  = 3'd5
    } cycle_t;

    localparam int TC_MEM_WR = 3;
    localparam int TC_IO_WR  = 4;

    // High phase of any T-state; each one counts one T-state.
    function automatic logic is_h_phase(input tstate_t s);
        return (s == ST_T1H) || (s == ST_T2H) ||
               (s == ST_TWH) || (s == ST_T3H);
    endfunction

endpackage

// File: rtl/z80_tcycle_counter.sv
// Saturating T-state counter shared by the bus sequencers.
// A clear in the same clk as an increment counts that T-state.
module z80_tcycle_counter #(
    parameter int TC_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            inc,
    output logic [TC_W-1:0] count
);

    localparam logic [TC_W-1:0] MAX = '1;
    localparam logic [TC_W-1:0] ONE = {{(TC_W-1){1'b0}}, 1'b1};

    // Count H phases, never wrapping past all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/z80_bus_write_cycle.sv
// Z80 write M-cycle sequencer (memory write and OUT).
// Drives address, data and strobes per half T-state.
module z80_bus_write_cycle
    import z80_bus_pkg::*;
#(
    parameter int TC_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req,
    input  logic [15:0]     req_addr,
    input  logic [7:0]      req_data,
    input  logic            req_io,
    output logic            ready,
    output logic            done,
    output logic [TC_W-1:0] tcycles,
    output logic [15:0]     bus_addr,
    output logic [7:0]      bus_dout,
    output logic            bus_doe,
    output logic            mreq_n,
    output logic            iorq_n,
    output logic            wr_n,
    input  logic            wait_n
);

    tstate_t         state;
    tstate_t         nxt;
    cycle_t          cyc_q;
    logic [7:0]      data_q;
    logic [TC_W-1:0] cnt;
    logic            is_io;
    logic            mreq_d;
    logic            iorq_d;
    logic            wr_d;
    logic            doe_d;

    assign is_io = (cyc_q == CYCLE_WR_IO);

    // Phase sequencing; I/O always takes one wait state.
    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: nxt = req ? ST_T1H : ST_IDLE;
            ST_T1H:  nxt = ST_T1L;
            ST_T1L:  nxt = ST_T2H;
            ST_T2H:  nxt = ST_T2L;
            ST_T2L:  nxt = (is_io || !wait_n) ? ST_TWH : ST_T3H;
            ST_TWH:  nxt = ST_TWL;
            ST_TWL:  nxt = wait_n ? ST_T3H : ST_TWH;
            ST_T3H:  nxt = ST_T3L;
            ST_T3L:  nxt = req ? ST_T1H : ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Strobe and data-enable levels for the phase being entered.
    always_comb begin
        mreq_d = !is_io && (nxt inside {ST_T1L, ST_T2H, ST_T2L,
                                        ST_TWH, ST_TWL, ST_T3H});
        iorq_d = is_io && (nxt inside {ST_T2H, ST_T2L,
                                       ST_TWH, ST_TWL, ST_T3H});
        wr_d   = (nxt inside {ST_T2L, ST_TWH, ST_TWL, ST_T3H}) ||
                 (is_io && (nxt == ST_T2H));
        doe_d  = (nxt inside {ST_T1L, ST_T2H, ST_T2L, ST_TWH,
                              ST_TWL, ST_T3H, ST_T3L}) ||
                 ((nxt == ST_T1H) && (state == ST_T3L));
    end

    z80_tcycle_counter #(
        .TC_W (TC_W)
    ) u_tc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (nxt == ST_T1H),
        .inc     (is_h_phase(nxt)),
        .count   (cnt)
    );

    // State, request latches and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cyc_q    <= CYCLE_WR_MEM;
            data_q   <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            tcycles  <= '0;
            bus_addr <= '0;
            bus_dout <= '0;
            bus_doe  <= 1'b0;
            mreq_n   <= 1'b1;
            iorq_n   <= 1'b1;
            wr_n     <= 1'b1;
        end else begin
            state   <= nxt;
            ready   <= (nxt == ST_IDLE) || (nxt == ST_T3L);
            done    <= (nxt == ST_T3L);
            bus_doe <= doe_d;
            mreq_n  <= !mreq_d;
            iorq_n  <= !iorq_d;
            wr_n    <= !wr_d;
            if (nxt == ST_T1H) begin
                cyc_q    <= req_io ? CYCLE_WR_IO : CYCLE_WR_MEM;
                data_q   <= req_data;
                bus_addr <= req_addr;
            end
            if (nxt == ST_T1L) begin
                bus_dout <= data_q;
            end
            if (nxt == ST_T3L) begin
                tcycles <= cnt;
            end
        end
    end

endmodule

// File: doc/z80_bus_write_cycle.md
Name: z80_bus_write_cycle

Overview:
- T-state sequencer that drives the external bus for one write M-cycle. Covers memory write (LD (HL),r and friends) and I/O write (OUT).
- Opposite direction of the memory-read M-cycle that LD r,(HL) depends on: the execution core supplies address and data, and this block generates MREQ_n/IORQ_n/WR_n with WAIT_n insertion.
- On completion it reports the cycle's T-state count, so z80fi can check tcycles against the instruction spec.

Parameters:
- TC_W, 4, width of the reported T-state count; saturates at 2**TC_W-1.

Ports:
- clk  in  1  clock at 2x the T-state rate; each T-state is two clk cycles, phase H then phase L.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request a write cycle; sampled only when ready=1.
- req_addr  in  16  target address.
- req_data  in  8  byte to write.
- req_io  in  1  0 = memory write, 1 = I/O write.
- ready  out  1  block can accept req this clk.
- done  out  1  one-clk pulse in the final phase (T3L).
- tcycles  out  TC_W  T-states consumed by the cycle; valid while done=1, otherwise held.
- bus_addr  out  16  address bus.
- bus_dout  out  8  data bus output.
- bus_doe  out  1  data bus output enable.
- mreq_n  out  1  memory request strobe.
- iorq_n  out  1  I/O request strobe.
- wr_n  out  1  write strobe.
- wait_n  in  1  external wait, synchronous to clk.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, ready=1, done=0, tcycles=0.
  - bus_addr=0, bus_dout=0, bus_doe=0, mreq_n=iorq_n=wr_n=1.
- Reset mid-cycle: strobes deassert and bus_doe drops at once. No done pulse is produced; the cycle is lost.
- States: IDLE, T1H, T1L, T2H, T2L, TWH, TWL, T3H, T3L. All outputs are registered.
- IDLE: ready=1. If req=1, latch addr/data/io and go to T1H on the next clk.
- T1H: bus_addr=latched address. Strobes remain high.
- T1L:
  - memory: mreq_n=0 and bus_doe=1 with bus_dout=data.
  - I/O: bus_doe=1 only.
- T2H: I/O only: iorq_n=0 and wr_n=0.
- T2L:
  - memory: wr_n=0. wait_n is sampled on the clk edge ending T2L; 0 -> TWH, 1 -> T3H.
  - I/O: always go to TWH (one mandatory wait state); wait_n is not sampled here.
- TWH then TWL: strobes held. wait_n is sampled at the end of TWL; 0 -> TWH again, 1 -> T3H. There is no limit on wait states.
- T3H: strobes held.
- T3L:
  - mreq_n, iorq_n and wr_n go to 1.
  - done=1 and tcycles is valid.
  - bus_doe stays 1 through T3L and drops to 0 on the next clk unless a new cycle starts.
  - ready=1 during T3L. If req=1, go directly to T1H with no idle gap; otherwise go to IDLE.
- tcycles:
  - memory: 3 + number of TW states.
  - I/O: 4 + number of extra TW states.
  - Saturates at 2**TC_W-1 and never wraps.
- bus_addr holds its last value in IDLE.
- req while ready=0 is ignored and not queued.
- Data and address latches are stable from T1H through T3L regardless of req_* changes.
- mreq_n and iorq_n are never low in the same clk.

Decomposition:
- Shared package z80_bus_pkg:
  - state enum for the T1H..T3L phases.
  - localparams TC_MEM_WR=3 and TC_IO_WR=4.
  - mcycle-type encodings CYCLE_WR_MEM and CYCLE_WR_IO, matching the z80fi cycle types.
- Sub-module z80_tcycle_counter: saturating TC_W counter with clear-on-T1H and increment-on-each-H-phase, shared later with the read-cycle sequencer.

Test Plan:
- Memory write, no wait: req addr=0x1234 data=0xA5 io=0 -> bus_addr=0x1234 from T1H; mreq_n low T1L..T2L..T3H; wr_n low T2L..T3H; done after 6 clk; tcycles=3.
- Memory write, wait_n=0 for two TWL samples: -> two TW states, wr_n held low throughout, tcycles=5; done at clk 10.
- I/O write, port 0x00FE data=0x07, wait_n=1 -> iorq_n and wr_n low T2H..T3H, mreq_n never low, one automatic TW, tcycles=4; done at clk 8.
- Back-to-back: req held across T3L with new addr 0x5678 -> T1H follows T3L immediately, bus_addr=0x5678, no IDLE clk, two done pulses 6 clk apart.
- Async reset asserted during T2L of a memory write -> wr_n, mreq_n and bus_doe inactive in the same clk; no done pulse; after release, ready=1 and the next req runs a normal 6-clk cycle.
- Saturation with TC_W=4 and wait_n held 0 for 20 TW states -> tcycles=15 at done, no wrap.
